fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory request at a time, feeding
// a small circular buffer of {pc, instruction} pairs toward the core.
module fetch_queue #(
  parameter int unsigned      Width   = 32,
  parameter int unsigned      Depth   = 4,
  parameter logic [Width-1:0] ResetPc = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  output logic [Width-1:0] imem_addr,
  output logic             imem_valid,
  input  logic             imem_ready,
  input  logic             imem_done,
  input  logic [Width-1:0] imem_data,
  output logic             out_valid,
  output logic [Width-1:0] out_instr,
  output logic [Width-1:0] out_pc,
  input  logic             out_ready
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t           state;
  logic [Width-1:0] fetch_pc;
  logic [Width-1:0] req_pc;
  logic [CW-1:0]    count;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [Width-1:0] buf_pc    [Depth];
  logic [Width-1:0] buf_instr [Depth];

  logic             accept;
  logic             push;
  logic             pop;
  logic [Width-1:0] push_pc;
  logic [CW-1:0]    count_next;
  logic             space;
  logic [Width-1:0] redirect_target;
  logic [Width-1:0] next_fetch_pc;

  always_comb begin
    accept          = (state == S_REQ) && imem_ready;
    pop             = (count != '0) && out_ready;
    push            = !redirect_valid && imem_done && ((state == S_WAIT) || accept);
    push_pc         = (state == S_WAIT) ? req_pc : imem_addr;
    count_next      = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    space           = count_next < CW'(Depth);
    redirect_target = redirect_pc & ~Width'(3);
    next_fetch_pc   = redirect_valid ? redirect_target
                    : (accept ? fetch_pc + Width'(4) : fetch_pc);
  end

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;
  assign out_pc    = out_valid ? buf_pc[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= push_pc;
      buf_instr[wr_ptr] <= imem_data;
    end
  end

  // Every transition into S_REQ loads imem_addr from next_fetch_pc, so a redirect
  // in the same cycle is already folded into the issued address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      fetch_pc   <= ResetPc;
      req_pc     <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      imem_valid <= 1'b0;
      imem_addr  <= ResetPc;
    end else begin
      count    <= count_next;
      fetch_pc <= next_fetch_pc;
      if (accept) req_pc <= imem_addr;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      case (state)
        S_IDLE: begin
          if (space) begin
            state      <= S_REQ;
            imem_valid <= 1'b1;
            imem_addr  <= next_fetch_pc;
          end
        end
        S_REQ: begin
          if (!imem_ready) begin
            imem_addr <= next_fetch_pc;
          end else if (imem_done) begin
            if (space) begin
              imem_addr <= next_fetch_pc;
            end else begin
              state      <= S_IDLE;
              imem_valid <= 1'b0;
            end
          end else begin
            state      <= redirect_valid ? S_DROP : S_WAIT;
            imem_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_done) begin
            if (space) begin
              state      <= S_REQ;
              imem_valid <= 1'b1;
              imem_addr  <= next_fetch_pc;
            end else begin
              state <= S_IDLE;
            end
          end else if (redirect_valid) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_done) begin
            state      <= S_REQ;
            imem_valid <= 1'b1;
            imem_addr  <= next_fetch_pc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small instruction memory responder model.
module tb_fetch_queue;

  localparam logic [31:0] K = 32'h1300_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic        imem_ready = 1'b0;
  logic        imem_done = 1'b0;
  logic [31:0] imem_data = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  int total = 0;
  int bad = 0;

  logic        mem_ready_en = 1'b1;
  int          mem_lat = 1;
  logic        acc = 1'b0;
  logic [31:0] acc_addr = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          acc_count = 0;

  fetch_queue #(.Width(32), .Depth(4), .ResetPc(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_ready(imem_ready),
    .imem_done(imem_done), .imem_data(imem_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Memory: a request accepted at a rising edge answers mem_lat cycles later.
  always @(negedge clk) begin
    imem_done = 1'b0;
    if (!rst) begin
      acc = 1'b0; pend = 1'b0; acc_count = 0; imem_ready = 1'b0;
    end else begin
      if (acc) begin
        pend = 1'b1; pend_addr = acc_addr; pend_cnt = mem_lat; acc = 1'b0;
      end
      if (pend) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          imem_done = 1'b1; imem_data = pend_addr + K; pend = 1'b0;
        end
      end
      imem_ready = mem_ready_en;
      if (imem_valid && imem_ready) begin
        acc = 1'b1; acc_addr = imem_addr; acc_count = acc_count + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    mem_ready_en = 1'b1; mem_lat = 1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++; if (imem_valid !== 1'b0) begin bad++; $display("FAIL reset_imem_valid got=%b want=0", imem_valid); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_imem_addr got=%h want=0", imem_addr); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", out_instr); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc got=%h want=0", out_pc); end
  endtask

  task automatic test_stream();
    int idx = 0;
    do_reset();
    out_ready = 1'b1;
    rst = 1'b1;
    for (int cyc = 1; cyc <= 40 && idx < 4; cyc++) begin
      tick();
      if (cyc == 1) begin
        total++; if (imem_valid !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req got valid=%b addr=%h want 1/0", imem_valid, imem_addr); end
      end
      if (out_valid === 1'b1) begin
        if (idx == 0) begin
          total++; if (cyc != 3) begin bad++; $display("FAIL first_latency got=%0d want=3", cyc); end
        end
        total++; if (out_pc !== 32'(idx * 4)) begin bad++; $display("FAIL stream_pc%0d got=%h want=%h", idx, out_pc, 32'(idx * 4)); end
        total++; if (out_instr !== 32'(idx * 4) + K) begin bad++; $display("FAIL stream_instr%0d got=%h want=%h", idx, out_instr, 32'(idx * 4) + K); end
        idx++;
      end
    end
    total++; if (idx != 4) begin bad++; $display("FAIL stream_timeout got=%0d want=4", idx); end
  endtask

  task automatic test_full();
    do_reset();
    rst = 1'b1;
    repeat (20) tick();
    total++; if (acc_count != 4) begin bad++; $display("FAIL full_accepts got=%0d want=4", acc_count); end
    total++; if (imem_valid !== 1'b0) begin bad++; $display("FAIL full_idle got=%b want=0", imem_valid); end
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL full_head got=%b/%h want=1/0", out_valid, out_pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (imem_valid !== 1'b1 || imem_addr !== 32'h10) begin bad++; $display("FAIL refill_req got=%b/%h want=1/10", imem_valid, imem_addr); end
    total++; if (out_pc !== 32'h4) begin bad++; $display("FAIL refill_head got=%h want=4", out_pc); end
    repeat (10) tick();
    total++; if (acc_count != 5) begin bad++; $display("FAIL refill_accepts got=%0d want=5", acc_count); end
    total++; if (imem_valid !== 1'b0) begin bad++; $display("FAIL refill_idle got=%b want=0", imem_valid); end
  endtask

  task automatic test_redirect_pop();
    bit seen = 0;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    total++; if (imem_valid !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL flush_req got=%b/%h want=1/200", imem_valid, imem_addr); end
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        seen = 1;
        total++; if (out_pc !== 32'h200 || out_instr !== 32'h200 + K) begin bad++; $display("FAIL flush_first got=%h/%h want=200/%h", out_pc, out_instr, 32'h200 + K); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL flush_timeout got=none want=out_valid"); end
  endtask

  task automatic test_redirect_wait();
    bit seen = 0;
    bit early = 0;
    do_reset();
    mem_lat = 3; out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    total++; if (imem_valid !== 1'b0) begin bad++; $display("FAIL wait_state got=%b want=0", imem_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (out_valid === 1'b1) early = 1;
      if (imem_valid === 1'b1) begin
        seen = 1;
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL drop_next_addr got=%h want=100", imem_addr); end
      end
    end
    total++; if (!seen || early) begin bad++; $display("FAIL drop_no_push got seen=%0d pushed=%0d want 1/0", seen, early); end
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        seen = 1;
        total++; if (out_pc !== 32'h100 || out_instr !== 32'h100 + K) begin bad++; $display("FAIL drop_first got=%h/%h want=100/%h", out_pc, out_instr, 32'h100 + K); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL drop_timeout got=none want=out_valid"); end
  endtask

  task automatic test_stall();
    bit seen = 0;
    do_reset();
    mem_ready_en = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (imem_valid !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL stall_hold%0d got=%b/%h want=1/0", i, imem_valid, imem_addr); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_valid !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL stall_retarget got=%b/%h want=1/40", imem_valid, imem_addr); end
    mem_ready_en = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        seen = 1;
        total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL stall_first got=%h want=40", out_pc); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL stall_timeout got=none want=out_valid"); end
  endtask

  task automatic test_reset_mid();
    bit reached = 0;
    bit seen = 0;
    do_reset();
    mem_lat = 3;
    rst = 1'b1;
    for (int c = 0; c < 30 && !reached; c++) begin
      tick();
      if (out_valid === 1'b1 && imem_valid === 1'b0) reached = 1;
    end
    total++; if (!reached) begin bad++; $display("FAIL midrst_setup got=none want=wait_state"); end
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0) begin bad++; $display("FAIL midrst_out got=%b/%h/%h want=0/0/0", out_valid, out_instr, out_pc); end
    total++; if (imem_valid !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_imem got=%b/%h want=0/0", imem_valid, imem_addr); end
    tick();
    rst = 1'b1; out_ready = 1'b1;
    tick();
    total++; if (imem_valid !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_restart got=%b/%h want=1/0", imem_valid, imem_addr); end
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        seen = 1;
        total++; if (out_pc !== 32'h0 || out_instr !== K) begin bad++; $display("FAIL midrst_first got=%h/%h want=0/%h", out_pc, out_instr, K); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL midrst_timeout got=none want=out_valid"); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_pop();
    test_redirect_wait();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
